// File: rtl/busmatrix_arbiter.sv
// Round-robin address-phase arbiter for one AHB slave port.
// Holds ownership through bursts, locks and wait states; drives the attribute/data mux selects.
module busmatrix_arbiter #(
  parameter int NUM_MASTERS = 16
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   hready,
  input  logic [1:0]             htrans_sel,
  input  logic                   hmastlock_sel,
  input  logic                   burst_last_sel,
  output logic [NUM_MASTERS-1:0] addr_sel,
  output logic [NUM_MASTERS-1:0] data_sel,
  output logic                   grant_valid,
  output logic [3:0]             hmaster
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {S_IDLE, S_OWNED} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] addr_q, addr_d, data_q, data_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [IW-1:0]          win, idx;
  logic                   win_vld, rearb;

  // The pointer always equals the current owner while OWNED, so one search
  // starting at ptr+1 serves both the IDLE grant and re-arbitration (owner last).
  always_comb begin
    win     = ptr_q;
    win_vld = 1'b0;
    idx     = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = IW'((int'(ptr_q) + k) % NUM_MASTERS);
      if (req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign rearb = hready && !hmastlock_sel &&
                 ((htrans_sel == 2'b00) || (burst_last_sel && htrans_sel[1]) || !req[ptr_q]);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      ptr_q   <= IW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    if (hready) data_d = htrans_sel[1] ? addr_q : '0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d     = S_OWNED;
          ptr_d       = win;
          addr_d      = '0;
          addr_d[win] = 1'b1;
        end
      end
      S_OWNED: begin
        if (rearb) begin
          if (win_vld) begin
            ptr_d       = win;
            addr_d      = '0;
            addr_d[win] = 1'b1;
          end else begin
            state_d = S_IDLE;
            addr_d  = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  always_comb begin
    grant_valid = |addr_q;
    hmaster     = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (addr_q[i]) hmaster = hmaster | 4'(i);
  end

  assign addr_sel = addr_q;
  assign data_sel = data_q;

endmodule

// File: doc/busmatrix_arbiter.md
# busmatrix_arbiter

Per-slave-port round-robin arbiter for the AHB bus matrix. Chooses which master interface owns the slave port's address phase. Drives the two one-hot selects that steer the port's config_mux instances:
- `addr_sel` drives the transaction-attribute mux.
- `data_sel` drives the HWDATA mux and the response mux.

Bursts and locked sequences are never broken. Ownership is re-arbitrated only at transfer boundaries qualified by `hready`.

## Interface
Parameters:
- NUM_MASTERS, 16, number of master interfaces competing for this slave port; legal values 1, 2, 4, 8, 16 (must equal the downstream mux MUX_SIZE)

Ports:
- hclk  input  1  bus clock; all state updates on rising edge
- hreset  input  1  synchronous, active-high reset
- req  input  NUM_MASTERS  per-master request; master i holds a pending transfer for this slave
- hready  input  1  slave port HREADY; 1 = current address/data phase completes this cycle
- htrans_sel  input  2  HTRANS of the currently selected owner (from the attribute mux); 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- hmastlock_sel  input  1  HMASTLOCK of the currently selected owner
- burst_last_sel  input  1  owner's address-phase transfer is the last of its burst
- addr_sel  output  NUM_MASTERS  one-hot address-phase owner; all-zero = no owner
- data_sel  output  NUM_MASTERS  one-hot data-phase owner; all-zero = no data phase
- grant_valid  output  1  addr_sel is non-zero
- hmaster  output  4  binary index of the addr_sel owner; 0 when no owner

## Operation
- States:
  - IDLE: no owner, addr_sel = 0.
  - OWNED: one bit of addr_sel set.
- IDLE -> OWNED: any req bit set at an edge. Winner is chosen round-robin. hready is not required for this transition; the mux presents IDLE (zeros) while unowned.
- Re-arbitration point in OWNED: edge with all of
  - hready = 1
  - hmastlock_sel = 0
  - (htrans_sel = IDLE, or burst_last_sel = 1 with htrans_sel in {NONSEQ, SEQ}, or req[owner] = 0)
- At a re-arbitration point:
  - Search order: owner+1, owner+2, …, wrapping modulo NUM_MASTERS, with owner last.
  - If the search finds a requester, addr_sel moves to it. The current owner keeps ownership only if no other master requests.
  - If there are no requests, go to IDLE.
- While OWNED and not at a re-arbitration point, addr_sel holds. This covers BUSY/SEQ mid-burst, locked sequences, and hready = 0.
- hmastlock_sel = 1 blocks re-arbitration even when htrans_sel = IDLE. Lock release is honoured at the first hready = 1 edge where hmastlock_sel = 0.
- data_sel:
  - On an edge with hready = 1: data_sel <= addr_sel if htrans_sel[1] = 1 (NONSEQ/SEQ), else 0.
  - On an edge with hready = 0: data_sel holds.
- Round-robin pointer = index of the last granted master. It updates only on a grant.
- hmaster and grant_valid are combinational decodes of the addr_sel register.
- NUM_MASTERS = 1: addr_sel[0] follows req at re-arbitration points; same rules otherwise.
- addr_sel and data_sel are always one-hot or zero. A non-one-hot value is a design error; the downstream mux outputs zeros for it.

## Timing
- Reset (hreset = 1 at an edge):
  - addr_sel = 0, data_sel = 0, grant_valid = 0, hmaster = 0, state IDLE.
  - Pointer = NUM_MASTERS-1, so master 0 has highest priority first.
  - Reset mid-burst discards ownership immediately.
- Grant latency from IDLE: req at edge N -> addr_sel valid after edge N.
- Handover: qualifying edge N -> new addr_sel after edge N. The old owner's data_sel is also loaded at edge N, so its data phase overlaps the new owner's address phase.
- Wait states (hready = 0): addr_sel, data_sel and pointer all frozen.
- Simultaneous requests resolve in the same cycle, strictly by pointer order.
- A req deasserting while its master is the owner (a master-side abort) is only acted on at an hready = 1 edge.

## Test plan
- Reset then req = 16'h0005 at one edge -> next cycle addr_sel = 16'h0001, hmaster = 0, grant_valid = 1. After master 0 completes a single NONSEQ with burst_last_sel = 1 and hready = 1 -> addr_sel = 16'h0004, data_sel = 16'h0001.
- All 16 req held high, every transfer single (burst_last_sel = 1), hready = 1 -> hmaster sequence 0,1,2,…,15,0.
- Master 3 INCR4: NONSEQ, SEQ, SEQ, SEQ (last) with req = 16'hFFFF and hready = 0 on the second beat -> addr_sel stays 16'h0008 for all 4 accepted beats plus the wait cycle, then moves to 16'h0010.
- Master 2 with hmastlock_sel = 1 issuing IDLE and NONSEQ singles while master 5 requests -> no handover until the first hready = 1 edge with hmastlock_sel = 0; then addr_sel = 16'h0020.
- Owner master 1 drops req, no other requests, hready = 1 -> addr_sel = 0, grant_valid = 0. data_sel = 0 if htrans_sel was IDLE, else 16'h0002.
- hreset asserted mid-burst with data_sel = 16'h0040 -> next cycle all outputs 0. Then req = 16'h8001 -> master 0 is granted first.
